// File: rtl/fp_mul_arb_pkg.sv
// Shared types and defaults for the fp_mul_arbiter slice.
package fp_mul_arb_pkg;
  localparam int FP_W        = 32;
  localparam int SETTLE_DEF  = 3;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Bundle of requester, response and multiplier-side signals around fp_mul_arbiter.
interface fp_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  import fp_mul_arb_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and its payload until that edge, ready never waits on
  // a later valid.
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FP_W-1:0] req_a;
  logic [NREQ*FP_W-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [FP_W-1:0]      rsp_result;
  logic                 rsp_err;
  logic [FP_W-1:0]      mul_a;
  logic [FP_W-1:0]      mul_b;
  logic [FP_W-1:0]      mul_result;
  logic                 mul_done;
  logic                 busy;
  arb_state_t           dbg_state;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_result, mul_done,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, mul_a, mul_b,
           busy, dbg_state
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_result, mul_done,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, mul_a, mul_b,
           busy, dbg_state
  );
endinterface

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);
  int idx;

  // Scan from the farthest slot back to ptr so the closest hit wins last.
  always_comb begin
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one free-running fp multiplier between NREQ requesters, round-robin.
// Optional watchdog enabled by defining FP_MUL_ARB_TIMEOUT_EN.
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int SETTLE  = SETTLE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic             clk,
  input logic             rst_n,
  fp_mul_arbiter_if.slave bus
);
  localparam int HW = $clog2(SETTLE + 2);

  if (NREQ < 2 || NREQ > 8 || SETTLE < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fp_mul_arbiter: unsupported NREQ/SETTLE/TIMEOUT");
  end

  arb_state_t      state, state_nxt;
  logic [IDW-1:0]  ptr, grant_id, rsp_id_q;
  logic [NREQ-1:0] grant;
  logic [HW-1:0]   hold_cnt;
  logic [FP_W-1:0] mul_a_q, mul_b_q, rsp_result_q;
  logic            hs, qual_done, tmo;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req      (bus.req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign hs = (state == IDLE) && (|bus.req_valid);
  // A done seen before SETTLE cycles of stable operands reports the previous operands.
  assign qual_done = (state == ISSUE) && bus.mul_done && (int'(hold_cnt) >= SETTLE);

`ifdef FP_MUL_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;
  logic          rsp_err_q;

  assign tmo = (state == ISSUE) && !qual_done && (int'(wd_cnt) == TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (hs) wd_cnt <= '0;
      else if (state == ISSUE) wd_cnt <= wd_cnt + 1'b1;
      if (hs) rsp_err_q <= 1'b0;
      else if (tmo) rsp_err_q <= 1'b1;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign tmo         = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = ISSUE;
      ISSUE:   if (qual_done || tmo) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      rsp_id_q     <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      hold_cnt     <= '0;
      rsp_result_q <= '0;
    end else begin
      if (hs) begin
        mul_a_q  <= bus.req_a[int'(grant_id)*FP_W +: FP_W];
        mul_b_q  <= bus.req_b[int'(grant_id)*FP_W +: FP_W];
        rsp_id_q <= grant_id;
        ptr      <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
        hold_cnt <= '0;
      end else if (state == ISSUE && int'(hold_cnt) < SETTLE) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (qual_done) rsp_result_q <= bus.mul_result;
      else if (tmo)  rsp_result_q <= '0;
    end
  end

  assign bus.req_ready  = (state == IDLE) ? grant : '0;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.busy       = (state != IDLE);
  assign bus.dbg_state  = state;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a free-running 3-phase multiplier model.
`timescale 1ns/1ps
module tb_fp_mul_arbiter;
  import fp_mul_arb_pkg::*;

  localparam int NREQ = 4;
  localparam logic [31:0] F1_0  = 32'h3F800000;
  localparam logic [31:0] F1_5  = 32'h3FC00000;
  localparam logic [31:0] F2_0  = 32'h40000000;
  localparam logic [31:0] F2_5  = 32'h40200000;
  localparam logic [31:0] F3_0  = 32'h40400000;
  localparam logic [31:0] F4_0  = 32'h40800000;
  localparam logic [31:0] F6_0  = 32'h40C00000;
  localparam logic [31:0] F8_0  = 32'h41000000;
  localparam logic [31:0] F10_0 = 32'h41200000;
  localparam logic [31:0] FM2_0 = 32'hC0000000;
  localparam logic [31:0] FM6_0 = 32'hC0C00000;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.NREQ(NREQ)) bus ();

  fp_mul_arbiter #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q[$];

  // multiplier model: capture, compute, writeback; done shows the capture of 3 cycles earlier
  logic [1:0]  mdl_ph    = 2'd0;
  logic [2:0]  mdl_prime = 3'd0;
  logic        mdl_en    = 1'b1;
  logic [31:0] mdl_ca = '0, mdl_cb = '0, mdl_prod = '0, mdl_res = '0;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s; int e; logic [47:0] m; logic [23:0] sig; logic [24:0] sr; logic g, st;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin sig = m[47:24]; g = m[23]; st = |m[22:0]; e = e + 1; end
    else begin sig = m[46:23]; g = m[22]; st = |m[21:0]; end
    sr = {1'b0, sig} + 25'(g && (st || sig[0]));
    if (sr[24]) begin sig = sr[24:1]; e = e + 1; end
    else sig = sr[23:0];
    return {s, e[7:0], sig[22:0]};
  endfunction

  always @(posedge clk) begin
    mdl_ph <= (mdl_ph == 2'd2) ? 2'd0 : mdl_ph + 2'd1;
    if (mdl_ph == 2'd0) begin
      mdl_ca <= bus.mul_a;
      mdl_cb <= bus.mul_b;
      if (mdl_prime != 3'd4) mdl_prime <= mdl_prime + 3'd1;
    end
    if (mdl_ph == 2'd1) mdl_prod <= fmul(mdl_ca, mdl_cb);
    if (mdl_ph == 2'd2) mdl_res <= mdl_prod;
  end

  assign bus.mul_done   = mdl_en && (mdl_ph == 2'd0) && (mdl_prime >= 3'd2);
  assign bus.mul_result = mdl_res;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
    check({tag, "_rsp_result"}, bus.rsp_result, 0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
    check({tag, "_mul_a"}, bus.mul_a, 0);
    check({tag, "_mul_b"}, bus.mul_b, 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  // driver: raise a request, drop each valid bit after its handshake, stop at rsp_valid
  task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic got);
    logic [NREQ-1:0] hs;
    bus.req_a[id*32 +: 32] = a;
    bus.req_b[id*32 +: 32] = b;
    bus.req_valid[id]      = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
      else begin
        hs = bus.req_ready & bus.req_valid;
        @(posedge clk);
        #1;
        lat++;
        bus.req_valid = bus.req_valid & ~hs;
      end
    end
  endtask

  task automatic expect_rsp(input string tag, input int id, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res);
    int lat; logic got;
    run_one(id, a, b, lat, got);
    check({tag, "_seen"}, 32'(got), 1);
    if (got) begin
      check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
      check({tag, "_result"}, bus.rsp_result, res);
      check({tag, "_err"}, 32'(bus.rsp_err), 0);
      check({tag, "_lat_5to7"}, 32'(lat >= 5 && lat <= 7), 1);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    int lat;
    logic got;
    logic [35:0] e;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // single request
    expect_rsp("single", 0, F1_5, F2_0, F3_0);

    // stale done at each of the three multiplier phase offsets
    for (int k = 0; k < 3; k++) begin
      expect_rsp($sformatf("prior_k%0d", k), 0, F1_0, F1_0, F1_0);
      repeat (k) tick();
      expect_rsp($sformatf("stale_k%0d", k), 1, F1_5, F2_0, F3_0);
    end

    // response backpressure (ptr now points at requester 2)
    bus.rsp_ready = 1'b0;
    run_one(2, F2_5, F4_0, lat, got);
    check("bp_seen", 32'(got), 1);
    bus.req_valid = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      check("bp_rsp_id", 32'(bus.rsp_id), 2);
      check("bp_rsp_result", bus.rsp_result, F10_0);
      check("bp_req_ready", 32'(bus.req_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_idle_busy", 32'(bus.busy), 0);

    // reset in the middle of ISSUE
    bus.req_a[3*32 +: 32] = F3_0;
    bus.req_b[3*32 +: 32] = F2_0;
    bus.req_valid[3]      = 1'b1;
    tick();
    bus.req_valid = '0;
    tick();
    check("mid_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_busy", 32'(bus.busy), 0);
    check("post_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    expect_rsp("post_rst", 0, F3_0, FM2_0, FM6_0);

    // round-robin with every requester asserting, from a fresh ptr
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.req_a = {F4_0, F3_0, F2_0, F1_0};
    bus.req_b = {F2_0, F2_0, F2_0, F2_0};
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({4'd0, F2_0});
      exp_q.push_back({4'd1, F4_0});
      exp_q.push_back({4'd2, F6_0});
      exp_q.push_back({4'd3, F8_0});
    end
    bus.req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        e = exp_q.pop_front();
        check($sformatf("rr%0d_id", n), 32'(bus.rsp_id), 32'(e[35:32]));
        check($sformatf("rr%0d_result", n), bus.rsp_result, e[31:0]);
        n++;
      end
      @(posedge clk);
      #1;
      if (n == 8) bus.req_valid = '0;
    end
    check("rr_count", 32'(n), 8);
    tick();

`ifdef FP_MUL_ARB_TIMEOUT_EN
    // watchdog: multiplier never answers
    mdl_en = 1'b0;
    run_one(1, F1_5, F2_0, lat, got);
    check("tmo_seen", 32'(got), 1);
    check("tmo_lat", 32'(lat), 65);
    check("tmo_err", 32'(bus.rsp_err), 1);
    check("tmo_result", bus.rsp_result, 0);
    tick();
    mdl_en = 1'b1;
    expect_rsp("tmo_after", 2, F2_5, F4_0, F10_0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
